pcm_frame_buffer: RTL and testbench

Downstream of the NRZ bit-sync/frame-sync stage. Takes its byte stream (data, enable, lock) and captures each locked frame of FRAME_SIZE bytes into one of two RAM banks. Completed frames go out as packets over a valid/ready byte interface toward the host link (UART/USB FIFO bridge). Each packet is two header bytes, a sequence byte, then the frame bytes. Truncated frames and frames with no free bank are dropped and counted.

---
 rtl/pcm_pkg.sv | 10 +
 rtl/pcm_frame_ram.sv | 25 ++
 rtl/pcm_frame_buffer.sv | 208 ++++++++++++++++++++
 tb/tb_pcm_frame_buffer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_pkg.sv
// Shared types and defaults for the PCM frame path.
// The frame size default must match the upstream frame sync.
package pcm_pkg;
  localparam int         PCM_FRAME_SIZE = 128;
  localparam logic [7:0] PCM_HDR0       = 8'hA5;
  localparam logic [7:0] PCM_HDR1       = 8'h5A;

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_e;
  typedef enum logic [2:0] {R_IDLE, R_HDR0, R_HDR1, R_SEQ, R_DATA} r_state_e;
endpackage

// File: rtl/pcm_frame_ram.sv
// Two-bank frame store: synchronous write port, synchronous read port.
// The read register holds its value while re is low, which the reader uses as a prefetch slot.
module pcm_frame_ram
  import pcm_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem_q [2**AW];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/pcm_frame_buffer.sv
// Captures locked frames into two RAM banks and emits them as
// HDR0/HDR1/seq/data packets over a valid/ready byte stream.
module pcm_frame_buffer
  import pcm_pkg::*;
#(
  parameter int         FRAME_SIZE = PCM_FRAME_SIZE,
  parameter logic [7:0] HDR0       = PCM_HDR0,
  parameter logic [7:0] HDR1       = PCM_HDR1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_en,
  input  logic       in_lock,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] drop_count,
  output logic [7:0] ovf_count,
  output logic       busy
);
  localparam int            IW   = $clog2(FRAME_SIZE);
  localparam int            AW   = IW + 1;
  localparam logic [IW-1:0] LAST = IW'(FRAME_SIZE - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  w_state_e        w_state_q, w_state_d;
  r_state_e        r_state_q, r_state_d;
  logic            lock_q;
  logic            w_bank_q, w_bank_d, r_bank_q, r_bank_d, older_q, older_d;
  logic [IW-1:0]   w_idx_q, w_idx_d, r_cnt_q, r_cnt_d;
  logic [1:0]      full_q, full_d;
  logic [1:0][7:0] tag_q, tag_d;
  logic [7:0]      seq_q, seq_d, drop_q, drop_d, ovf_q, ovf_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;

  logic            w_commit, r_release, r_sel, hs;
  logic            ram_we, ram_re;
  logic [AW-1:0]   ram_waddr, ram_raddr;
  logic [7:0]      ram_rdata;

  pcm_frame_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (in_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    w_state_d = w_state_q;
    w_bank_d  = w_bank_q;
    w_idx_d   = w_idx_q;
    drop_d    = drop_q;
    ovf_d     = ovf_q;
    w_commit  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = {w_bank_q, w_idx_q};
    case (w_state_q)
      W_IDLE: begin
        if (in_lock && !lock_q) begin
          if (full_q != 2'b11) begin
            w_bank_d  = full_q[0];
            w_idx_d   = '0;
            w_state_d = W_FILL;
          end else begin
            ovf_d     = sat_inc8(ovf_q);
            w_state_d = W_DROP;
          end
        end
      end
      W_FILL: begin
        // The final byte commits even if lock drops on that same cycle.
        if (in_en && w_idx_q == LAST) begin
          ram_we    = 1'b1;
          w_commit  = 1'b1;
          w_state_d = W_IDLE;
        end else if (!in_lock) begin
          drop_d    = sat_inc8(drop_q);
          w_state_d = W_IDLE;
        end else if (in_en) begin
          ram_we  = 1'b1;
          w_idx_d = w_idx_q + IW'(1);
        end
      end
      W_DROP: if (!in_lock) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  assign hs = out_valid_q && out_ready;

  always_comb begin
    r_state_d   = r_state_q;
    r_bank_d    = r_bank_q;
    r_cnt_d     = r_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    r_release   = 1'b0;
    r_sel       = 1'b0;
    ram_re      = 1'b0;
    ram_raddr   = {r_bank_q, r_cnt_q + IW'(2)};
    case (r_state_q)
      R_IDLE: begin
        if (|full_q) begin
          r_sel       = (&full_q) ? older_q : full_q[1];
          r_bank_d    = r_sel;
          ram_re      = 1'b1;
          ram_raddr   = {r_sel, {IW{1'b0}}};
          out_data_d  = HDR0;
          out_valid_d = 1'b1;
          r_state_d   = R_HDR0;
        end
      end
      R_HDR0: if (hs) begin
        out_data_d = HDR1;
        r_state_d  = R_HDR1;
      end
      R_HDR1: if (hs) begin
        out_data_d = tag_q[r_bank_q];
        r_state_d  = R_SEQ;
      end
      R_SEQ: if (hs) begin
        // Byte 0 was prefetched on entry; fetch byte 1 while byte 0 is presented.
        out_data_d = ram_rdata;
        r_cnt_d    = '0;
        ram_re     = 1'b1;
        ram_raddr  = {r_bank_q, IW'(1)};
        r_state_d  = R_DATA;
      end
      R_DATA: if (hs) begin
        if (r_cnt_q == LAST) begin
          r_release   = 1'b1;
          out_valid_d = 1'b0;
          r_state_d   = R_IDLE;
        end else begin
          out_data_d = ram_rdata;
          r_cnt_d    = r_cnt_q + IW'(1);
          ram_re     = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // The older flag names the bank committed first whenever both are full.
  always_comb begin
    full_d  = full_q;
    tag_d   = tag_q;
    seq_d   = seq_q;
    older_d = older_q;
    if (w_commit) begin
      full_d[w_bank_q] = 1'b1;
      tag_d[w_bank_q]  = seq_q;
      seq_d            = seq_q + 8'd1;
      older_d          = full_q[~w_bank_q] ? ~w_bank_q : w_bank_q;
    end
    if (r_release) full_d[r_bank_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      lock_q      <= 1'b0;
      w_bank_q    <= 1'b0;
      r_bank_q    <= 1'b0;
      older_q     <= 1'b0;
      w_idx_q     <= '0;
      r_cnt_q     <= '0;
      full_q      <= '0;
      tag_q       <= '0;
      seq_q       <= '0;
      drop_q      <= '0;
      ovf_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      lock_q      <= in_lock;
      w_bank_q    <= w_bank_d;
      r_bank_q    <= r_bank_d;
      older_q     <= older_d;
      w_idx_q     <= w_idx_d;
      r_cnt_q     <= r_cnt_d;
      full_q      <= full_d;
      tag_q       <= tag_d;
      seq_q       <= seq_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign drop_count = drop_q;
  assign ovf_count  = ovf_q;
  assign busy       = (|full_q) || (r_state_q != R_IDLE) || (w_state_q == W_FILL);
endmodule

// File: tb/tb_pcm_frame_buffer.sv
// Randomized bench for pcm_frame_buffer with a frame-level reference model.
module tb_pcm_frame_buffer;
  import pcm_pkg::*;

  localparam int FS = 128;
  localparam int PL = FS + 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_en = 1'b0;
  logic       in_lock = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] drop_count, ovf_count;
  logic       busy;

  pcm_frame_buffer #(.FRAME_SIZE(FS), .HDR0(8'hA5), .HDR1(8'h5A)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_en      (in_en),
    .in_lock    (in_lock),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_count (drop_count),
    .ovf_count  (ovf_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic [7:0] got[$];
  int         got_cyc[$];
  int         cyc = 0;
  int         stall_viol = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         ready_mode = 1'b0;
  bit         ready_val = 1'b0;

  logic [7:0] exp_q[$];
  int         reset_base = 0;
  int         chk_idx = 0;
  int         committed = 0;
  logic [7:0] seq_m = 8'h00;
  logic [7:0] drop_m = 8'h00;
  logic [7:0] ovf_m = 8'h00;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_val;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        got_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic int held();
    return committed - (got.size() - reset_base) / PL;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    exp_q.delete();
    chk_idx    = 0;
    committed  = 0;
    seq_m      = 8'h00;
    drop_m     = 8'h00;
    ovf_m      = 8'h00;
    reset_base = got.size();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_en   = 1'b0;
    in_lock = 1'b0;
    repeat (3) tick();
    reset_model();
    reset_n = 1'b1;
    tick();
  endtask

  // A frame is stored only if fewer than two completed frames are still undrained.
  task automatic send_frame(input int nbytes, input bit ramp, input bit gaps);
    logic [7:0] fr[$];
    logic [7:0] b;
    bit acc;
    acc = (held() < 2);
    if (!acc) ovf_m = sat8(ovf_m);
    in_lock = 1'b1;
    tick();
    for (int i = 0; i < nbytes; i++) begin
      if (gaps && ($urandom % 4 == 0)) begin
        in_en = 1'b0;
        tick();
      end
      b = ramp ? 8'(i) : 8'($urandom);
      in_data = b;
      in_en = 1'b1;
      fr.push_back(b);
      tick();
    end
    in_en   = 1'b0;
    in_lock = 1'b0;
    tick();
    tick();
    if (acc) begin
      if (nbytes == FS) begin
        exp_q.push_back(PCM_HDR0);
        exp_q.push_back(PCM_HDR1);
        exp_q.push_back(seq_m);
        foreach (fr[k]) exp_q.push_back(fr[k]);
        seq_m = seq_m + 8'd1;
        committed++;
      end else begin
        drop_m = sat8(drop_m);
      end
    end
  endtask

  task automatic check_packets(input string name);
    int n = 0;
    int ngot;
    while ((got.size() - reset_base) < exp_q.size() && n < 3000) begin
      tick();
      n++;
    end
    repeat (5) tick();
    ngot = got.size() - reset_base;
    n_chk++;
    if (ngot != exp_q.size())
      $display("FAIL %s_len: got %0d bytes, expected %0d", name, ngot, exp_q.size());
    else n_pass++;
    for (int i = chk_idx; i < exp_q.size() && i < ngot; i++) begin
      n_chk++;
      if (got[reset_base + i] !== exp_q[i])
        $display("FAIL %s_byte[%0d]: got %h, expected %h", name, i, got[reset_base + i], exp_q[i]);
      else n_pass++;
    end
    chk_idx = exp_q.size();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b, expected 0", out_valid); else n_pass++;
    n_chk++; if (out_data !== 8'h00) $display("FAIL rst_data: got %h, expected 00", out_data); else n_pass++;
    n_chk++; if (drop_count !== 8'h00) $display("FAIL rst_drop: got %h, expected 00", drop_count); else n_pass++;
    n_chk++; if (ovf_count !== 8'h00) $display("FAIL rst_ovf: got %h, expected 00", ovf_count); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, expected 0", busy); else n_pass++;
  endtask

  task automatic test_clean_frame();
    int first;
    do_reset();
    ready_mode = 1'b0;
    ready_val  = 1'b1;
    first = got.size();
    send_frame(FS, 1'b1, 1'b0);
    n_chk++; if (busy !== 1'b1) $display("FAIL clean_busy_hi: got %b, expected 1", busy); else n_pass++;
    check_packets("clean");
    n_chk++;
    if (got.size() < first + PL)
      $display("FAIL clean_b2b: got %0d bytes, expected %0d", got.size() - first, PL);
    else if (got_cyc[first + PL - 1] - got_cyc[first] != PL - 1)
      $display("FAIL clean_b2b: got span %0d cycles, expected %0d", got_cyc[first + PL - 1] - got_cyc[first], PL - 1);
    else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL clean_busy_lo: got %b, expected 0", busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    int v0;
    v0 = stall_viol;
    ready_mode = 1'b1;
    send_frame(FS, 1'b0, 1'b1);
    check_packets("bp");
    ready_mode = 1'b0;
    ready_val  = 1'b1;
    n_chk++; if (stall_viol != v0) $display("FAIL bp_stable: got %0d stall violations, expected 0", stall_viol - v0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready_val = 1'b1;
    send_frame(FS, 1'b0, 1'b1);
    send_frame(FS, 1'b0, 1'b0);
    check_packets("b2b");
  endtask

  task automatic test_truncation();
    do_reset();
    ready_val = 1'b1;
    send_frame(50, 1'b0, 1'b0);
    n_chk++; if (drop_count !== drop_m) $display("FAIL trunc_drop: got %h, expected %h", drop_count, drop_m); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL trunc_busy: got %b, expected 0", busy); else n_pass++;
    send_frame(FS, 1'b0, 1'b0);
    check_packets("trunc");
  endtask

  task automatic test_overflow();
    do_reset();
    ready_val = 1'b0;
    repeat (3) send_frame(FS, 1'b0, 1'b0);
    n_chk++; if (ovf_count !== ovf_m) $display("FAIL ovf_count: got %h, expected %h", ovf_count, ovf_m); else n_pass++;
    n_chk++; if (drop_count !== drop_m) $display("FAIL ovf_drop: got %h, expected %h", drop_count, drop_m); else n_pass++;
    n_chk++; if (out_valid !== 1'b1 || out_data !== PCM_HDR0) $display("FAIL ovf_stall: got valid %b data %h, expected 1 a5", out_valid, out_data); else n_pass++;
    ready_val = 1'b1;
    check_packets("ovf");
  endtask

  task automatic test_saturation();
    do_reset();
    ready_val = 1'b1;
    repeat (260) send_frame(2, 1'b0, 1'b0);
    n_chk++; if (drop_count !== drop_m) $display("FAIL sat_drop: got %h, expected %h", drop_count, drop_m); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    int n = 0;
    do_reset();
    ready_val = 1'b1;
    send_frame(10, 1'b0, 1'b0);
    send_frame(FS, 1'b0, 1'b0);
    while ((got.size() - reset_base) < 43 && n < 500) begin
      tick();
      n++;
    end
    n_chk++; if ((got.size() - reset_base) < 43) $display("FAIL mid_reach: got %0d bytes, expected 43", got.size() - reset_base); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %b, expected 0", out_valid); else n_pass++;
    n_chk++; if (drop_count !== 8'h00) $display("FAIL mid_drop: got %h, expected 00", drop_count); else n_pass++;
    n_chk++; if (ovf_count !== 8'h00) $display("FAIL mid_ovf: got %h, expected 00", ovf_count); else n_pass++;
    repeat (2) tick();
    reset_model();
    reset_n = 1'b1;
    tick();
    send_frame(FS, 1'b0, 1'b0);
    check_packets("mid");
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_backpressure();
    test_back_to_back();
    test_truncation();
    test_overflow();
    test_saturation();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
